arbiter_rr: RTL and testbench
=============================

# arbiter_rr

Parametrised N-requester arbiter with registered one-hot grant, grant hold (lock until release), run-time selectable fixed-priority or round-robin policy, and optional max-hold preemption. It replaces the fixed 16-input priority arbiter at each router output port: one instance per output port, where request[i] is input port i asking for that output. The added hold timeout and round-robin mode stop long packets or low-index ports from starving the others.

## Interface
- N_REQ, 16, number of requesters; legal values are 2 and up, and powers of two are not required.
- MAX_HOLD, 0, maximum number of consecutive cycles one owner may hold the grant while another requester waits; 0 means unlimited.
- IDX_W, $clog2(N_REQ), derived width of the encoded index; not overridden.
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- request  input  N_REQ  request[i]=1 means requester i wants the grant; level-sensitive, held for the whole transfer.
- mode_rr  input  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- grant  output  N_REQ  registered, one-hot or all zero.
- grant_idx  output  IDX_W  binary index of the set grant bit; 0 when grant==0.
- busy  output  1  equals |grant.
- preempt  output  1  registered one-cycle pulse, set in the first cycle of a grant that was won by a max-hold preemption.

## Operation
- State consists of grant, ptr (IDX_W bits, round-robin start index), hold_cnt (width $clog2(MAX_HOLD+1), minimum 1) and preempt.
- Arbitration function win(mask):
  - Fixed mode: the lowest set index of request & mask.
  - Round-robin mode: the first set index of request & mask, searching ptr, ptr+1, … N_REQ-1, 0, … ptr-1.
  - No eligible request: result is none.
- Next-state rules at each clock edge, with owner o = current grant index:
  - Idle (grant==0): grant <= onehot(win(all ones)), or 0 if none.
  - Held, request[o]=0 (release): grant <= onehot(win(all ones)) in the same edge, with no idle bubble. grant goes to 0 only if no requests remain.
  - Held, request[o]=1, MAX_HOLD≠0, hold_cnt==MAX_HOLD, and request & ~onehot(o) ≠ 0 (preempt): grant <= onehot(win(~onehot(o))) and preempt <= 1.
  - Held otherwise: grant unchanged.
- hold_cnt:
  - Loads 1 whenever a new grant is loaded, including a change of owner.
  - Increments while the same owner is retained, saturating at MAX_HOLD.
  - Loads 0 when grant becomes 0.
  - Is ignored when MAX_HOLD=0.
- ptr:
  - On every newly loaded grant with winner w, ptr <= (w==N_REQ-1) ? 0 : w+1.
  - Updated in both modes, so a switch to round-robin continues fairly.
- preempt is 0 on every edge that is not a preemption.
- mode_rr:
  - Sampled at each arbitration edge.
  - A change never disturbs a held grant; it affects only the next arbitration.
- An owner that is preempted but keeps its request asserted competes normally at the next arbitration.
  - In round-robin mode it is the lowest priority there.
  - In fixed mode it may win straight back once the new owner releases.
- If the owner is the only requester when hold_cnt==MAX_HOLD, it keeps the grant, hold_cnt stays saturated, and preempt stays 0.

## Timing
- Reset (asynchronous, reset_n low): grant=0, grant_idx=0, busy=0, preempt=0, ptr=0, hold_cnt=0, effective immediately without waiting for a clock edge.
- First arbitration happens on the first rising edge with reset_n high.
- Latency: a request sampled at edge t appears in grant just after edge t, i.e. one clock.
- grant_idx and busy are combinational from the grant register, so they are valid in the same cycle as grant.
- With MAX_HOLD=M≠0 and contention, an owner is granted for exactly M cycles, then the next owner takes over on the following edge.
- Simultaneous release and expiry is treated as a release: preempt=0.
- Simultaneous requests: exactly one winner per edge; grant is never more than one-hot.
- Round-robin wrap: with ptr=N_REQ-1 and only request[0] set, the winner is 0 and ptr becomes 1.
- Reset asserted mid-grant: all state clears immediately. After release, round-robin restarts from ptr=0.

## Test plan
- Reset: hold request=16'hFFFF with reset_n low, then release with mode_rr=0 → grant=0 and busy=0 during reset; after the first edge, grant=16'h0001, grant_idx=0, busy=1.
- Hold without limit (MAX_HOLD=0, mode_rr=0): owner 5 granted, then request=16'h0021 for 10 cycles → grant stays 16'h0020; when request[5] drops, the next edge gives grant=16'h0001 with no zero cycle.
- Round-robin with preemption (N_REQ=16, MAX_HOLD=2, mode_rr=1): request=16'h8003 held constant → grant_idx follows 0,0,1,1,15,15,0,0; preempt pulses in the first cycle of each new owner after the initial grant.
- Fixed-mode preemption (MAX_HOLD=3, mode_rr=0): owner 2 granted, request=16'h0104 → after 3 cycles grant=16'h0100 with preempt=1; when request[8] drops, grant returns to 16'h0004.
- Sole requester at expiry (MAX_HOLD=2): request=16'h0400 for 8 cycles → grant=16'h0400 throughout, preempt never set.
- Asynchronous reset mid-grant: grant=16'h0080 in round-robin mode, pulse reset_n low between edges → grant drops to 0 before the next edge; after release with request=16'h8001, the winner is 0 because ptr was reset.

Source files
------------

// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between the router input ports and one output-port arbiter.
// The master side drives requests and the policy select; the slave side returns the grant.
interface arbiter_rr_if #(
  parameter int unsigned N_REQ = 16
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] request;
  logic             mode_rr;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             preempt;

  modport master (
    output request, mode_rr,
    input  grant, grant_idx, busy, preempt
  );

  modport slave (
    input  request, mode_rr,
    output grant, grant_idx, busy, preempt
  );
endinterface

// File: rtl/arbiter_rr.sv
// N-requester arbiter: registered one-hot grant held until release, fixed or round-robin
// policy, and optional max-hold preemption so one owner cannot starve the others.
module arbiter_rr #(
  parameter int unsigned N_REQ    = 16,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  arbiter_rr_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned HC_W  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic [IDX_W-1:0] owner_c;
  logic [IDX_W-1:0] start_c;
  logic [N_REQ-1:0] others_c;
  logic [IDX_W:0]   win_all_c;
  logic [IDX_W:0]   win_oth_c;
  logic [IDX_W:0]   win_c;
  logic             load_c;

  // Circular search from start; returns {found, index}. Fixed mode passes start = 0.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] req,
                                          input logic [IDX_W-1:0] start);
    logic [IDX_W:0] res;
    int unsigned    j;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(start) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!res[IDX_W] && req[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  always_comb begin
    owner_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner_c = IDX_W'(i);
    end
  end

  assign start_c   = bus.mode_rr ? ptr_q : '0;
  assign others_c  = bus.request & ~grant_q;
  assign win_all_c = pick(bus.request, start_c);
  assign win_oth_c = pick(others_c, start_c);

  // Next-state: arbitrate on idle/release, preempt on expiry under contention, else hold.
  always_comb begin
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    load_c    = 1'b0;
    win_c     = win_all_c;

    if ((grant_q == '0) || !bus.request[owner_c]) begin
      load_c = 1'b1;
    end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others_c)) begin
      load_c    = 1'b1;
      win_c     = win_oth_c;
      preempt_d = 1'b1;
    end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HC_W'(1);
    end

    if (load_c) begin
      if (win_c[IDX_W]) begin
        grant_d = N_REQ'(1) << win_c[IDX_W-1:0];
        hold_d  = HC_W'(1);
        ptr_d   = (win_c[IDX_W-1:0] == LAST_IDX) ? '0 : win_c[IDX_W-1:0] + IDX_W'(1);
      end else begin
        grant_d = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = owner_c;
  assign bus.busy      = |grant_q;
  assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr: three instances (MAX_HOLD 0, 2, 3) exercised in turn.
module tb_arbiter_rr;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [3:0] rr_idx [8];
  logic       rr_pre [8];

  arbiter_rr_if #(.N_REQ(16)) if0 ();
  arbiter_rr_if #(.N_REQ(16)) if2 ();
  arbiter_rr_if #(.N_REQ(16)) if3 ();

  arbiter_rr #(.N_REQ(16), .MAX_HOLD(0)) u_h0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  arbiter_rr #(.N_REQ(16), .MAX_HOLD(2)) u_h2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  arbiter_rr #(.N_REQ(16), .MAX_HOLD(3)) u_h3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rr_idx = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd15, 4'd15, 4'd0, 4'd0};
    rr_pre = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset_n     = 1'b0;
    if0.request = 16'hFFFF;
    if0.mode_rr = 1'b0;
    if2.request = 16'h0000;
    if2.mode_rr = 1'b1;
    if3.request = 16'h0000;
    if3.mode_rr = 1'b0;

    // Reset holds grant at zero despite clock edges
    repeat (2) tick();
    check("rst_grant", 32'(if0.grant), 32'h0);
    check("rst_busy", 32'(if0.busy), 32'h0);
    check("rst_preempt", 32'(if0.preempt), 32'h0);
    reset_n = 1'b1;
    tick();
    check("first_grant", 32'(if0.grant), 32'h0001);
    check("first_idx", 32'(if0.grant_idx), 32'd0);
    check("first_busy", 32'(if0.busy), 32'h1);

    // Unlimited hold, then release handover without idle bubble
    if0.request = 16'h0020;
    tick();
    check("h0_own5", 32'(if0.grant), 32'h0020);
    check("h0_idx5", 32'(if0.grant_idx), 32'd5);
    if0.request = 16'h0021;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("h0_hold", 32'(if0.grant), 32'h0020);
    end
    if0.request = 16'h0001;
    tick();
    check("h0_handover", 32'(if0.grant), 32'h0001);
    check("h0_handover_busy", 32'(if0.busy), 32'h1);
    if0.request = 16'h0000;
    tick();
    check("h0_idle", 32'(if0.grant), 32'h0);
    check("h0_idle_idx", 32'(if0.grant_idx), 32'd0);
    check("h0_idle_busy", 32'(if0.busy), 32'h0);

    // Round-robin rotation driven by max-hold preemption
    if2.request = 16'h8003;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_idx", 32'(if2.grant_idx), 32'(rr_idx[i]));
      check("rr_preempt", 32'(if2.preempt), 32'(rr_pre[i]));
      check("rr_busy", 32'(if2.busy), 32'h1);
    end
    if2.request = 16'h0000;
    tick();
    check("rr_idle", 32'(if2.grant), 32'h0);

    // Sole requester keeps grant past expiry
    if2.request = 16'h0400;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("sole_grant", 32'(if2.grant), 32'h0400);
      check("sole_preempt", 32'(if2.preempt), 32'h0);
    end
    if2.request = 16'h0000;
    tick();

    // Fixed-priority preemption after exactly three cycles
    if3.request = 16'h0004;
    tick();
    check("fx_own2", 32'(if3.grant), 32'h0004);
    if3.request = 16'h0104;
    tick();
    check("fx_hold2", 32'(if3.grant), 32'h0004);
    check("fx_hold2_pre", 32'(if3.preempt), 32'h0);
    tick();
    check("fx_hold3", 32'(if3.grant), 32'h0004);
    check("fx_hold3_pre", 32'(if3.preempt), 32'h0);
    tick();
    check("fx_preempt_grant", 32'(if3.grant), 32'h0100);
    check("fx_preempt_pulse", 32'(if3.preempt), 32'h1);
    tick();
    check("fx_new_hold", 32'(if3.grant), 32'h0100);
    check("fx_pulse_end", 32'(if3.preempt), 32'h0);
    if3.request = 16'h0004;
    tick();
    check("fx_return", 32'(if3.grant), 32'h0004);
    check("fx_return_pre", 32'(if3.preempt), 32'h0);

    // Release coinciding with expiry counts as a release
    if3.request = 16'h0104;
    tick();
    check("rel_exp_h2", 32'(if3.grant), 32'h0004);
    tick();
    check("rel_exp_h3", 32'(if3.grant), 32'h0004);
    if3.request = 16'h0100;
    tick();
    check("rel_exp_grant", 32'(if3.grant), 32'h0100);
    check("rel_exp_pre", 32'(if3.preempt), 32'h0);
    if3.request = 16'h0000;
    tick();

    // Asynchronous reset mid-grant, then round-robin restarts at index 0
    if2.request = 16'h0080;
    tick();
    check("ar_grant", 32'(if2.grant), 32'h0080);
    check("ar_idx", 32'(if2.grant_idx), 32'd7);
    reset_n = 1'b0;
    #2;
    check("ar_clear_grant", 32'(if2.grant), 32'h0);
    check("ar_clear_busy", 32'(if2.busy), 32'h0);
    check("ar_clear_idx", 32'(if2.grant_idx), 32'd0);
    if2.request = 16'h8001;
    #1;
    reset_n = 1'b1;
    tick();
    check("ar_restart_grant", 32'(if2.grant), 32'h0001);
    check("ar_restart_idx", 32'(if2.grant_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
